// File: rtl/periph_bus_arbiter_pkg.sv
// Shared types for the two-master peripheral bus arbiter:
// FSM state encoding, master id type, bench-visible peripheral base.
package periph_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CAPT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    typedef logic mid_t;

    localparam mid_t MID_M0 = 1'b0;
    localparam mid_t MID_M1 = 1'b1;

    localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;

    // Access fault for the latched direction.
    function automatic logic acc_err(
        input logic we,
        input logic r_acc,
        input logic w_acc
    );
        return we ? ~w_acc : ~r_acc;
    endfunction

endpackage

// File: rtl/periph_rr_pick.sv
// Combinational 2-way winner select. Ports: req[1:0], last (last granted
// id), any (some request), winner (id). FIXED_PRI=1 gives master 0 ties.
module periph_rr_pick #(
    parameter int FIXED_PRI = 0
) (
    input  logic [1:0] req,
    input  logic       last,
    output logic       any,
    output logic       winner
);

    import periph_bus_arbiter_pkg::*;

    logic tie_win;

    assign tie_win = (FIXED_PRI != 0) ? MID_M0 : mid_t'(~last);

    always_comb begin
        any    = |req;
        winner = MID_M0;
        unique case (1'b1)
            (req == 2'b10): winner = MID_M1;
            (req == 2'b11): winner = tie_win;
            default:        winner = MID_M0;
        endcase
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master arbiter onto a single-strobe peripheral port, fixed 4-cycle
// transactions IDLE->ISSUE->CAPT->DONE.
// Ports: clk, reset (async, active-low); per master mN_req/we/addr/wdata
// in, mN_gnt/done/rdata/err out; peripheral pr_rd/pr_wr/pr_addr/pr_wdata
// out, pr_rdata/pr_r_acc/pr_w_acc in.
// Option ARB_ERR_LOG_EN adds err_clr in, err_valid/err_addr out: a sticky
// log of the first faulting address.
module periph_bus_arbiter #(
    parameter int FIXED_PRI = 0
) (
    input  logic        reset,
    input  logic        clk,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_done,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
`ifdef ARB_ERR_LOG_EN
    input  logic        err_clr,
    output logic        err_valid,
    output logic [31:0] err_addr,
`endif
    output logic        pr_rd,
    output logic        pr_wr,
    output logic [31:0] pr_addr,
    output logic [31:0] pr_wdata,
    input  logic [31:0] pr_rdata,
    input  logic        pr_r_acc,
    input  logic        pr_w_acc
);

    import periph_bus_arbiter_pkg::*;

    arb_state_t  state_q;
    arb_state_t  state_d;

    logic [1:0]  req_vec;
    logic        any_req;
    logic        win;
    logic        grant;

    logic        owner_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        last_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        cap_err;

    assign req_vec = {m1_req, m0_req};
    assign grant   = (state_q == ST_IDLE) && any_req;
    assign cap_err = acc_err(we_q, pr_r_acc, pr_w_acc);

    periph_rr_pick #(
        .FIXED_PRI(FIXED_PRI)
    ) u_pick (
        .req    (req_vec),
        .last   (last_q),
        .any    (any_req),
        .winner (win)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_req) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_CAPT;
            ST_CAPT:  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Request fields are frozen at grant so masters may change them
    // freely while their transaction is in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= MID_M0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= MID_M1;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (grant) begin
                owner_q <= win;
                last_q  <= win;
                we_q    <= win ? m1_we    : m0_we;
                addr_q  <= win ? m1_addr  : m0_addr;
                wdata_q <= win ? m1_wdata : m0_wdata;
            end
            // Peripheral data is registered on its side during ISSUE,
            // so it is valid to sample in CAPT.
            if (state_q == ST_CAPT) begin
                rdata_q <= we_q ? 32'h0 : pr_rdata;
                err_q   <= cap_err;
            end
        end
    end

    always_comb begin
        m0_gnt   = 1'b0;
        m1_gnt   = 1'b0;
        m0_done  = 1'b0;
        m1_done  = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;
        m0_err   = 1'b0;
        m1_err   = 1'b0;
        pr_rd    = 1'b0;
        pr_wr    = 1'b0;
        pr_addr  = '0;
        pr_wdata = '0;
        unique case (1'b1)
            (state_q == ST_ISSUE): begin
                m0_gnt   = (owner_q == MID_M0);
                m1_gnt   = (owner_q == MID_M1);
                pr_rd    = ~we_q;
                pr_wr    = we_q;
                pr_addr  = addr_q;
                pr_wdata = wdata_q;
            end
            (state_q == ST_CAPT): begin
                m0_gnt = (owner_q == MID_M0);
                m1_gnt = (owner_q == MID_M1);
            end
            (state_q == ST_DONE): begin
                if (owner_q == MID_M0) begin
                    m0_done  = 1'b1;
                    m0_rdata = rdata_q;
                    m0_err   = err_q;
                end else begin
                    m1_done  = 1'b1;
                    m1_rdata = rdata_q;
                    m1_err   = err_q;
                end
            end
            default: begin
            end
        endcase
    end

`ifdef ARB_ERR_LOG_EN
    // Sticky first-fault log; a clear beats an error in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else if (err_clr) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else if ((state_q == ST_CAPT) && cap_err && !err_valid) begin
            err_valid <= 1'b1;
            err_addr  <= addr_q;
        end
    end
`endif

endmodule

// File: doc/periph_bus_arbiter.md
PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

Interface
REQ-001 SHALL have parameter: FIXED_PRI, 0, 0 = round-robin between masters, 1 = master 0 always wins ties.
REQ-002 SHALL have ports:
- reset  in  1  asynchronous, active-low.
- clk  in  1  clock.
- mN_req (N=0,1)  in  1  level request, held until done.
- mN_we  in  1  1 = write, 0 = read.
- mN_addr  in  32  address.
- mN_wdata  in  32  write data.
- mN_gnt  out  1  high in ISSUE and CAPT while master N owns the bus.
- mN_done  out  1  one-cycle completion pulse.
- mN_rdata  out  32  read data, valid while done is high.
- mN_err  out  1  address not accessible, valid while done is high.
- pr_rd  out  1  peripheral read strobe.
- pr_wr  out  1  peripheral write strobe.
- pr_addr  out  32  peripheral address.
- pr_wdata  out  32  peripheral write data.
- pr_rdata  in  32  peripheral read data, registered by the peripheral.
- pr_r_acc  in  1  peripheral read-accessible flag.
- pr_w_acc  in  1  peripheral write-accessible flag.

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, CAPT, DONE.
REQ-004 IDLE: SHALL move to ISSUE when any req is high, latching winner id, we, addr and wdata at that edge; otherwise SHALL stay in IDLE.
REQ-005 ISSUE: SHALL drive pr_rd = ~we or pr_wr = we for exactly one cycle, with pr_addr/pr_wdata taken from the latch; then SHALL go to CAPT.
REQ-006 CAPT: strobes SHALL be low; SHALL register pr_rdata (reads only; writes return 0) and err = ~pr_r_acc (read) or ~pr_w_acc (write); then SHALL go to DONE.
REQ-007 DONE: SHALL assert mN_done of the owner with the registered rdata/err; then SHALL go to IDLE.
REQ-008 Latency SHALL be fixed: req sampled at edge k gives done high in cycle k+3; a transaction SHALL take 4 cycles including the IDLE cycle.
REQ-009 Requester SHALL drop req at the edge where it samples done = 1; a req still high in IDLE SHALL be treated as a new request.
REQ-010 Round-robin: on simultaneous req, SHALL grant the master not granted last; the last-granted pointer SHALL update on every grant.
REQ-011 A single requester SHALL always win regardless of the pointer.
REQ-012 Changes to mN_addr/we/wdata after grant SHALL have no effect on the transaction in flight.
REQ-013 A req from the non-owner SHALL wait without loss and SHALL be served at the next IDLE.
REQ-014 pr_addr/pr_wdata SHALL be 0 outside ISSUE.
REQ-015 At most one gnt SHALL be high, and at most one of pr_rd/pr_wr SHALL be high, in any cycle.

Reset
REQ-016 reset low SHALL force IDLE asynchronously, regardless of state.
REQ-017 Under reset, all outputs SHALL be 0 and the pointer SHALL be set to master 1, so master 0 wins the first tie.
REQ-018 A transaction interrupted by reset SHALL be abandoned, with no done issued after reset release.

Configuration
REQ-019 With ARB_ERR_LOG_EN defined, the block SHALL add outputs err_valid (1) and err_addr (32), and input err_clr (1).
REQ-020 With ARB_ERR_LOG_EN, the first errored transaction SHALL set err_valid and capture its address (sticky); later errors SHALL be ignored until err_clr.
REQ-021 With ARB_ERR_LOG_EN, err_clr SHALL win over a simultaneous new error, and err_valid/err_addr SHALL reset to 0.
REQ-022 Without ARB_ERR_LOG_EN, these ports and registers SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-023 Shared package SHALL hold the FSM state encoding (2-bit), the master-id type, and the peripheral base address 32'h40000000 for bench use.
REQ-024 A sub-module periph_rr_pick SHALL hold the combinational 2-way round-robin winner select (req[1:0], pointer, FIXED_PRI -> winner).

Verification
REQ-025 m0 read of 32'h40000014, pr_rdata = 32'h000000A5, pr_r_acc = 1 -> pr_rd in cycle k+1 only; m0_done in k+3 with rdata 32'h000000A5, err 0.
REQ-026 m1 write of 32'h00000003 to 32'h40000008 -> pr_wr one cycle with pr_wdata 32'h00000003; m1_done with err 0, rdata 0.
REQ-027 Both req high continuously from reset -> grants alternate m0, m1, m0, m1, every 4 cycles; with FIXED_PRI = 1 -> m0 always.
REQ-028 m0 read of 32'h40000020 with pr_r_acc = 0 -> m0_err = 1, rdata 0; with ARB_ERR_LOG_EN -> err_valid = 1, err_addr = 32'h40000020, held through a second error to 32'h40000024 until err_clr.
REQ-029 reset asserted in CAPT -> all outputs 0 immediately; no done after release; the next request completes normally.
